// File: rtl/sdm_ratio_meter_if.sv
// Measurement bus between the ratio meter and its control/readout side.
// The master modport is the meter; the slave modport is the register/debug consumer.
interface sdm_ratio_meter_if #(
    parameter int unsigned WIN_LOG2 = 10
);
    logic                  enable;
    logic [5:0]            div_ctrl;
    logic [5:0]            n_int;
    logic                  meas_ack;
    logic [WIN_LOG2+5:0]   meas_sum;
    logic [WIN_LOG2+6:0]   meas_err;
    logic [5:0]            meas_min;
    logic [5:0]            meas_max;
    logic                  meas_valid;
    logic                  meas_ovr;
    logic                  busy;

    modport master (
        input  enable, div_ctrl, n_int, meas_ack,
        output meas_sum, meas_err, meas_min, meas_max, meas_valid, meas_ovr, busy
    );

    modport slave (
        output enable, div_ctrl, n_int, meas_ack,
        input  meas_sum, meas_err, meas_min, meas_max, meas_valid, meas_ovr, busy
    );
endinterface

// File: rtl/sdm_ratio_meter.sv
// Divider-ratio meter: sums the SDM-modulated divide word over 2^WIN_LOG2 divided-clock
// cycles, reports sum, signed error vs. the expected integer ratio, and min/max, with a
// valid/ack handshake and a sticky overrun flag.
module sdm_ratio_meter #(
    parameter int unsigned WIN_LOG2 = 10
) (
    input logic               div_clk_out,
    input logic               rstn_clkin_s,
    sdm_ratio_meter_if.master bus
);
    localparam int unsigned SumW = WIN_LOG2 + 6;
    localparam int unsigned ErrW = WIN_LOG2 + 7;
    localparam logic [WIN_LOG2-1:0] CntLast = {WIN_LOG2{1'b1}};

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e              state_q, state_d;
    logic [SumW-1:0]     acc_q, acc_d;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [5:0]          run_min_q, run_min_d;
    logic [5:0]          run_max_q, run_max_d;
    logic [5:0]          n_cap_q, n_cap_d;
    logic [SumW-1:0]     sum_q, sum_d;
    logic [ErrW-1:0]     err_q, err_d;
    logic [5:0]          min_q, min_d;
    logic [5:0]          max_q, max_d;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;
    logic                busy_q;

    logic [SumW-1:0]     samp_sum;
    logic [5:0]          samp_min;
    logic [5:0]          samp_max;

    // Running values including the sample on this edge.
    always_comb begin
        samp_sum = acc_q + SumW'(bus.div_ctrl);
        samp_min = (bus.div_ctrl < run_min_q) ? bus.div_ctrl : run_min_q;
        samp_max = (bus.div_ctrl > run_max_q) ? bus.div_ctrl : run_max_q;
    end

    // Next-state: window sequencing, result capture and handshake.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        run_min_d = run_min_q;
        run_max_d = run_max_q;
        n_cap_d   = n_cap_q;
        sum_d     = sum_q;
        err_d     = err_q;
        min_d     = min_q;
        max_d     = max_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;

        // An ack consumes the pending result; a capture on the same edge re-raises valid.
        if (bus.meas_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.enable) begin
                    state_d   = StAccum;
                    acc_d     = '0;
                    cnt_d     = '0;
                    run_min_d = 6'd63;
                    run_max_d = 6'd0;
                    n_cap_d   = bus.n_int;
                end
            end
            StAccum: begin
                if (!bus.enable) begin
                    // Abort: partial window dropped, results left as they are.
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    sum_d   = samp_sum;
                    err_d   = ErrW'(samp_sum) - ErrW'({n_cap_q, {WIN_LOG2{1'b0}}});
                    min_d   = samp_min;
                    max_d   = samp_max;
                    valid_d = 1'b1;
                    if (valid_q && !bus.meas_ack) begin
                        ovr_d = 1'b1;
                    end
                    acc_d     = '0;
                    cnt_d     = '0;
                    run_min_d = 6'd63;
                    run_max_d = 6'd0;
                    n_cap_d   = bus.n_int;
                end else begin
                    acc_d     = samp_sum;
                    cnt_d     = cnt_q + WIN_LOG2'(1);
                    run_min_d = samp_min;
                    run_max_d = samp_max;
                end
            end
        endcase
    end

    // State and result registers, asynchronous active-low reset.
    always_ff @(posedge div_clk_out or negedge rstn_clkin_s) begin
        if (!rstn_clkin_s) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            run_min_q <= '0;
            run_max_q <= '0;
            n_cap_q   <= '0;
            sum_q     <= '0;
            err_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            run_min_q <= run_min_d;
            run_max_q <= run_max_d;
            n_cap_q   <= n_cap_d;
            sum_q     <= sum_d;
            err_q     <= err_d;
            min_q     <= min_d;
            max_q     <= max_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            busy_q    <= (state_d == StAccum);
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        bus.meas_sum   = sum_q;
        bus.meas_err   = err_q;
        bus.meas_min   = min_q;
        bus.meas_max   = max_q;
        bus.meas_valid = valid_q;
        bus.meas_ovr   = ovr_q;
        bus.busy       = busy_q;
    end
endmodule

// File: tb/tb_sdm_ratio_meter.sv
// Scoreboard bench for sdm_ratio_meter with a 16-cycle window. Stimulus pushes the
// hand-computed result of each window; a monitor pops and compares on every meas_valid rise.
module tb_sdm_ratio_meter;
    localparam int unsigned W = 4;

    logic div_clk_out = 1'b0;
    logic rstn_clkin_s = 1'b0;

    sdm_ratio_meter_if #(.WIN_LOG2(W)) bus ();

    sdm_ratio_meter #(.WIN_LOG2(W)) dut (
        .div_clk_out  (div_clk_out),
        .rstn_clkin_s (rstn_clkin_s),
        .bus          (bus)
    );

    initial forever #5 div_clk_out = ~div_clk_out;

    typedef struct {
        int sum;
        int err;
        int mn;
        int mx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic auto_ack = 1'b0;
    logic ack_auto_drv = 1'b0;
    logic man_ack = 1'b0;

    assign bus.meas_ack = ack_auto_drv | man_ack;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge div_clk_out);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sum"}, int'(bus.meas_sum), 0);
        check({tag, "_err"}, int'(bus.meas_err), 0);
        check({tag, "_min"}, int'(bus.meas_min), 0);
        check({tag, "_max"}, int'(bus.meas_max), 0);
        check({tag, "_valid"}, int'(bus.meas_valid), 0);
        check({tag, "_ovr"}, int'(bus.meas_ovr), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    // One full window alternating a/b; n_next is the ratio captured at this window's end.
    task automatic run_window(input int a, input int b, input int n_next,
                              input int e_sum, input int e_err, input int e_mn, input int e_mx,
                              input bit lat, input int ack_off_at, input bit push,
                              input bit ack_last);
        exp_t e;
        if (push) begin
            e.sum = e_sum;
            e.err = e_err;
            e.mn  = e_mn;
            e.mx  = e_mx;
            exp_q.push_back(e);
        end
        bus.n_int = 6'(n_next);
        for (int i = 0; i < 16; i++) begin
            bus.div_ctrl = 6'((i % 2 == 0) ? a : b);
            step();
            if (i == ack_off_at) auto_ack = 1'b0;
            if (lat && i == 14) check("latency_valid_low", int'(bus.meas_valid), 0);
            if (lat && i == 15) check("latency_valid_high", int'(bus.meas_valid), 1);
            if (ack_last && i == 14) man_ack = 1'b1;
        end
        man_ack = 1'b0;
    endtask

    // Auto-acknowledge: ack any pending result seen on the falling edge.
    initial forever begin
        @(negedge div_clk_out);
        ack_auto_drv = auto_ack && bus.meas_valid;
    end

    // Monitor: a new result is presented whenever meas_valid rises.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge div_clk_out);
            if (bus.meas_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got sum %0d, expected no result (t=%0t)",
                             bus.meas_sum, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_sum", int'(bus.meas_sum), e.sum);
                    check("mon_err", int'($signed(bus.meas_err)), e.err);
                    check("mon_min", int'(bus.meas_min), e.mn);
                    check("mon_max", int'(bus.meas_max), e.mx);
                end
            end
            prev_valid = bus.meas_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;
        bus.enable   = 1'b0;
        bus.div_ctrl = 6'd0;
        bus.n_int    = 6'd0;
        step();
        check_zero("reset");
        rstn_clkin_s = 1'b1;
        step();

        // Constant ratio, then continuous windows.
        auto_ack     = 1'b1;
        bus.n_int    = 6'd30;
        bus.div_ctrl = 6'd30;
        bus.enable   = 1'b1;
        step();
        check("busy_after_start", int'(bus.busy), 1);
        run_window(30, 30, 30, 480, 0, 30, 30, 1'b1, -1, 1'b1, 1'b0);
        run_window(30, 30, 30, 480, 0, 30, 30, 1'b1, -1, 1'b1, 1'b0);
        // Alternating ratio against n=30 then n=31.
        run_window(30, 31, 31, 488, 8, 30, 31, 1'b1, -1, 1'b1, 1'b0);
        run_window(30, 31, 0, 488, -8, 30, 31, 1'b1, -1, 1'b1, 1'b0);
        // Extremes.
        run_window(63, 63, 63, 1008, 1008, 63, 63, 1'b1, -1, 1'b1, 1'b0);
        run_window(0, 0, 30, 0, -1008, 0, 0, 1'b1, -1, 1'b1, 1'b0);

        // Handshake: stop acking, let the next result be overwritten.
        run_window(30, 30, 30, 480, 0, 30, 30, 1'b0, 0, 1'b1, 1'b0);
        run_window(20, 20, 30, 0, 0, 0, 0, 1'b0, -1, 1'b0, 1'b0);
        check("ovr_set", int'(bus.meas_ovr), 1);
        check("ovr_valid", int'(bus.meas_valid), 1);
        check("ovr_sum", int'(bus.meas_sum), 320);
        check("ovr_err", int'($signed(bus.meas_err)), -160);
        check("ovr_min", int'(bus.meas_min), 20);
        check("ovr_max", int'(bus.meas_max), 20);
        // Ack coincident with the third capture.
        run_window(40, 40, 30, 0, 0, 0, 0, 1'b0, -1, 1'b0, 1'b1);
        check("simul_valid", int'(bus.meas_valid), 1);
        check("simul_ovr", int'(bus.meas_ovr), 0);
        check("simul_sum", int'(bus.meas_sum), 640);
        check("simul_err", int'($signed(bus.meas_err)), 160);
        // Isolated ack (first sample of the next window).
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        check("ack_valid_clear", int'(bus.meas_valid), 0);
        check("ack_ovr_clear", int'(bus.meas_ovr), 0);

        // Abort after 7 samples.
        repeat (6) step();
        check("busy_before_abort", int'(bus.busy), 1);
        bus.enable = 1'b0;
        step();
        check("busy_after_abort", int'(bus.busy), 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.meas_valid) seen = 1'b1;
        end
        check("abort_no_valid", int'(seen), 0);
        check("abort_sum_kept", int'(bus.meas_sum), 640);
        check("abort_err_kept", int'($signed(bus.meas_err)), 160);

        // Re-enable: full-window result after 16 cycles; leave it pending.
        auto_ack   = 1'b1;
        bus.n_int  = 6'd25;
        bus.enable = 1'b1;
        step();
        check("busy_restart", int'(bus.busy), 1);
        run_window(25, 26, 10, 408, 8, 25, 26, 1'b1, 14, 1'b1, 1'b0);

        // Reset at sample 9 of the next window with a result pending.
        bus.div_ctrl = 6'd10;
        repeat (9) step();
        check("pre_reset_valid", int'(bus.meas_valid), 1);
        rstn_clkin_s = 1'b0;
        #1;
        check_zero("async_reset");
        bus.enable = 1'b0;
        step();
        step();
        rstn_clkin_s = 1'b1;
        auto_ack   = 1'b1;
        bus.n_int  = 6'd10;
        bus.enable = 1'b1;
        step();
        run_window(10, 12, 10, 176, 16, 10, 12, 1'b1, -1, 1'b1, 1'b0);

        bus.enable = 1'b0;
        repeat (3) step();
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sdm_ratio_meter.md
# sdm_ratio_meter

Measures the division-ratio sequence applied to the loop divider and recovers its average as an integer sum over a programmable window. It sits in the divided-clock domain beside the SDM/loop-divider pair. It samples the 6-bit divider control word on every divided-clock edge and reports three quantities per window:
- the window sum,
- the signed error against the expected integer N,
- the minimum and maximum control words.

Results are passed to the register/debug side through a valid/ack handshake. The block is a decoder for the SDM-modulated ratio stream and is used to check fractional-N accuracy in silicon and in simulation.

## Interface
Parameters:
- WIN_LOG2, 10, log2 of window length in div_clk_out cycles; legal range 1..16

Ports:
- div_clk_out  in  1  clock, divided loop clock
- rstn_clkin_s  in  1  reset, asynchronous, active-low
- enable  in  1  1 = run measurement windows back to back; 0 = stop and abort
- div_ctrl  in  6  unsigned divide ratio, registered in the div_clk_out domain
- n_int  in  6  unsigned expected integer ratio, captured at window start
- meas_ack  in  1  consumer acknowledge of current result
- meas_sum  out  WIN_LOG2+6  unsigned sum of div_ctrl over the window
- meas_err  out  WIN_LOG2+7  signed, meas_sum − (n_int_captured << WIN_LOG2)
- meas_min  out  6  minimum div_ctrl seen in the window
- meas_max  out  6  maximum div_ctrl seen in the window
- meas_valid  out  1  result registers hold an unacknowledged result
- meas_ovr  out  1  sticky; a result was overwritten before being acked
- busy  out  1  state is ACCUM

## Operation
- Reset values:
  - state = IDLE
  - all outputs 0
  - internal accumulator, sample counter, running min/max and captured n_int at 0
- FSM states: IDLE and ACCUM.
  - IDLE → ACCUM when enable = 1 at a clock edge. On that edge:
    - acc ← 0, cnt ← 0, run_min ← 63, run_max ← 0
    - n_cap ← n_int
  - In ACCUM, every edge with enable = 1 takes one sample:
    - acc ← acc + div_ctrl
    - run_min/run_max updated with div_ctrl
    - cnt ← cnt + 1
  - Final sample is the edge where cnt = 2^WIN_LOG2 − 1. On that edge:
    - meas_sum ← acc + div_ctrl, and meas_min/meas_max include that sample
    - meas_err ← (acc + div_ctrl) − (n_cap << WIN_LOG2)
    - meas_valid ← 1
    - acc, cnt and run_min/run_max re-initialise; n_cap ← n_int
    - state stays ACCUM, so windows run continuously
  - ACCUM → IDLE when enable = 0 at any edge. The partial window is discarded; result registers and meas_valid are untouched.
- Arithmetic:
  - Sum cannot overflow: 63·2^WIN_LOG2 < 2^(WIN_LOG2+6).
  - meas_err is computed in WIN_LOG2+7 bits two's complement with both operands zero-extended, so no overflow is possible.
- Handshake:
  - meas_ack = 1 while meas_valid = 1: meas_valid ← 0 and meas_ovr ← 0 on that edge.
  - meas_ack while meas_valid = 0 is ignored.
- Overrun: a capture while meas_valid = 1 and meas_ack = 0 overwrites the result registers, keeps meas_valid = 1 and sets meas_ovr.
- Simultaneous capture and ack:
  - The new result loads and meas_valid stays 1.
  - meas_ovr is cleared, not set; the old result counts as consumed.
- Reset asserted mid-window: asynchronous return to reset values. The partial window and any pending result are lost.

## Timing
- All logic is on posedge div_clk_out. Reset assertion is asynchronous. Deassertion is already synchronised to div_clk_in upstream.
- Samples are taken on edges k+1 … k+2^WIN_LOG2 after the edge k on which enable was sampled high in IDLE.
- meas_valid rises immediately after edge k+2^WIN_LOG2, i.e. a latency of 2^WIN_LOG2 cycles from start.
- In continuous mode results arrive every 2^WIN_LOG2 cycles, with no dead cycle between windows.
- busy is a registered decode of state: 1 from edge k onward, 0 after the edge where enable is sampled low.
- meas_valid and meas_ovr clear one edge after meas_ack is sampled.
- Changes of n_int take effect only at the next window start.

## Test plan
All scenarios use WIN_LOG2 = 4 (16-cycle window).
- **Constant ratio:** div_ctrl = 30, n_int = 30, enable held → meas_sum = 480, meas_err = 0, meas_min = meas_max = 30. meas_valid rises 16 cycles after the start edge, then every 16 cycles.
- **Alternating ratio:** div_ctrl alternating 30/31, n_int = 30 → meas_sum = 488, meas_err = +8, min = 30, max = 31. With n_int = 31 instead: meas_err = −8.
- **Extremes:** div_ctrl = 63 for 16 cycles, n_int = 0 → meas_sum = 1008, meas_err = +1008. div_ctrl = 0, n_int = 63 → meas_sum = 0, meas_err = −1008.
- **Handshake and overrun:**
  - No ack across two windows → meas_ovr = 1, second window's values shown.
  - Ack in the same cycle as the third capture → meas_valid stays 1, meas_ovr = 0.
  - Isolated ack → meas_valid = 0 next cycle.
- **Abort:** enable dropped after 7 samples → busy = 0, no meas_valid rise, prior result unchanged. Re-enable → first valid appears 16 cycles later with a full-window sum.
- **Reset mid-window:** assert rstn_clkin_s low at sample 9 with meas_valid = 1 → all outputs 0 immediately. After release plus enable, the first result matches a clean 16-sample window.
